// File: rtl/median_window_gen_if.sv
// Stream bundle for median_window_gen: pixel input handshake and 3x3 window output handshake.
// master = upstream/downstream environment, slave = the window generator.
interface median_window_gen_if #(
    parameter int PIX_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_pixel;
    logic               out_valid;
    logic               out_ready;
    logic [9*PIX_W-1:0] out_win;
    logic [9:0]         out_x;
    logic [9:0]         out_y;
    logic               out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_win, out_x, out_y, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_win, out_x, out_y, out_last
    );
endinterface

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator with two-line buffer; zero-padded borders by default,
// nearest-tap replication when WIN_BORDER_REPLICATE_EN is defined.
module median_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    median_window_gen_if.slave bus
);
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int AW = $clog2(IMG_W);
    localparam logic [XW-1:0] X_PAD = XW'(IMG_W);
    localparam logic [YW-1:0] Y_PAD = YW'(IMG_H);

    typedef logic [PIX_W-1:0] pix_t;

    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          pad_col;
    logic          pad_row;
    logic          pad;
    logic          emitting;
    logic          step;
    logic [AW-1:0] col;

    // lb_top holds row sy-2, lb_mid holds row sy-1 at each column
    pix_t lb_top [IMG_W];
    pix_t lb_mid [IMG_W];

    pix_t win    [3][3];
    pix_t nxt    [3][3];
    pix_t shaped [3][3];
    pix_t new_col [3];

    logic [9*PIX_W-1:0] win_flat;

    logic               out_valid_q;
    logic [9*PIX_W-1:0] out_win_q;
    logic [9:0]         out_x_q;
    logic [9:0]         out_y_q;
    logic               out_last_q;

    assign pad_col  = (sx == X_PAD);
    assign pad_row  = (sy == Y_PAD);
    assign pad      = pad_col || pad_row;
    assign emitting = (sx != '0) && (sy != '0);
    assign step     = (pad || bus.in_valid) && (!emitting || !out_valid_q || bus.out_ready);
    assign col      = AW'(sx);

    assign bus.in_ready  = step && !pad;
    assign bus.out_valid = out_valid_q;
    assign bus.out_win   = out_win_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_last  = out_last_q;

    // Pad rows still read the buffered rows; only the pad column is entirely zero.
    always_comb begin
        new_col[0] = '0;
        new_col[1] = '0;
        new_col[2] = '0;
        if (!pad_col) begin
            new_col[0] = lb_top[col];
            new_col[1] = lb_mid[col];
            if (!pad_row) begin
                new_col[2] = bus.in_pixel;
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            nxt[r][0] = win[r][1];
            nxt[r][1] = win[r][2];
            nxt[r][2] = new_col[r];
        end
    end

    always_comb begin
        shaped = nxt;
`ifdef WIN_BORDER_REPLICATE_EN
        if (sx == XW'(1)) begin
            for (int unsigned r = 0; r < 3; r++) shaped[r][0] = shaped[r][1];
        end
        if (pad_col) begin
            for (int unsigned r = 0; r < 3; r++) shaped[r][2] = shaped[r][1];
        end
        if (sy == YW'(1)) begin
            for (int unsigned c = 0; c < 3; c++) shaped[0][c] = shaped[1][c];
        end
        if (pad_row) begin
            for (int unsigned c = 0; c < 3; c++) shaped[2][c] = shaped[1][c];
        end
`else
        // Masking the top row / left column hides stale line-buffer data from earlier frames.
        if (sy == YW'(1)) begin
            for (int unsigned c = 0; c < 3; c++) shaped[0][c] = '0;
        end
        if (sx == XW'(1)) begin
            for (int unsigned r = 0; r < 3; r++) shaped[r][0] = '0;
        end
`endif
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                win_flat[PIX_W*(3*r+c) +: PIX_W] = shaped[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step && !pad) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx <= '0;
            sy <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (step) begin
            win <= nxt;
            if (pad_col) begin
                sx <= '0;
                sy <= pad_row ? '0 : sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_last_q  <= 1'b0;
        end else if (step && emitting) begin
            out_valid_q <= 1'b1;
            out_win_q   <= win_flat;
            out_x_q     <= 10'(sx) - 10'd1;
            out_y_q     <= 10'(sy) - 10'd1;
            out_last_q  <= pad_col && pad_row;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen (4x3 image): clamped/zero-padded reference windows
// are queued per frame and checked by an independent output monitor.
module tb_median_window_gen;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;

    typedef struct {
        logic [9*PW-1:0] win;
        int              x;
        int              y;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    median_window_gen_if #(.PIX_W(PW)) bus ();

    median_window_gen #(
        .IMG_W(W),
        .IMG_H(H),
        .PIX_W(PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic mon_en = 1'b0;
    logic rnd_ready = 1'b0;
    int   win_count = 0;
    logic [9*PW-1:0] seen_win  [H][W];
    logic            seen_last [H][W];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [9*PW-1:0] pk(int a0, int a1, int a2, int a3, int a4,
                                           int a5, int a6, int a7, int a8);
        int t[9];
        logic [9*PW-1:0] v;
        t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        v = '0;
        for (int k = 0; k < 9; k++) v[PW*k +: PW] = PW'(t[k]);
        return v;
    endfunction

    // Reference pixel lookup for any (x,y), including coordinates outside the image.
    function automatic int tap(int base, int x, int y);
        int xx = x;
        int yy = y;
`ifdef WIN_BORDER_REPLICATE_EN
        if (xx < 0) xx = 0;
        if (xx >= W) xx = W - 1;
        if (yy < 0) yy = 0;
        if (yy >= H) yy = H - 1;
`else
        if (xx < 0 || xx >= W || yy < 0 || yy >= H) return 0;
`endif
        return base + 10 * yy + xx;
    endfunction

    task automatic push_frame(input int base);
        exp_t e;
        for (int cy = 0; cy < H; cy++) begin
            for (int cx = 0; cx < W; cx++) begin
                e.win = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.win[PW*(3*r+c) +: PW] = PW'(tap(base, cx + c - 1, cy + r - 1));
                e.x = cx;
                e.y = cy;
                e.last = (cx == W - 1) && (cy == H - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_pixels(input int base, input int n, input bit gaps);
        int idx = 0;
        int idle = 0;
        logic acc;
        while (idx < n) begin
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_pixel = PW'(base + 10 * (idx / W) + (idx % W));
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                idle = 0;
            end else if (++idle > 200) begin
                chk("input_accept_timeout", 128'(idx), 128'(n));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        push_frame(base);
        send_pixels(base, W * H, gaps);
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: hold-stability and in-order scoreboard comparison.
    initial begin
        logic            hold = 1'b0;
        logic [9*PW-1:0] hold_win;
        logic [9:0]      hold_x;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 128'(bus.out_valid), 128'(1));
                    chk("hold_win", 128'(bus.out_win), 128'(hold_win));
                    chk("hold_x", 128'(bus.out_x), 128'(hold_x));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got x=%0d y=%0d expected none",
                                 bus.out_x, bus.out_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("win", 128'(bus.out_win), 128'(e.win));
                        chk("x", 128'(bus.out_x), 128'(e.x));
                        chk("y", 128'(bus.out_y), 128'(e.y));
                        chk("last", 128'(bus.out_last), 128'(e.last));
                    end
                    if (bus.out_x < W && bus.out_y < H) begin
                        seen_win[bus.out_y][bus.out_x]  = bus.out_win;
                        seen_last[bus.out_y][bus.out_x] = bus.out_last;
                    end
                    win_count++;
                end
                hold = bus.out_valid && !bus.out_ready;
                hold_win = bus.out_win;
                hold_x = bus.out_x;
            end
        end
    end

    task automatic check_frame0(input string tag);
`ifdef WIN_BORDER_REPLICATE_EN
        chk({tag, "_w00"}, 128'(seen_win[0][0]), 128'(pk(0, 0, 1, 0, 0, 1, 10, 10, 11)));
        chk({tag, "_w32"}, 128'(seen_win[2][3]), 128'(pk(12, 13, 13, 22, 23, 23, 22, 23, 23)));
`else
        chk({tag, "_w00"}, 128'(seen_win[0][0]), 128'(pk(0, 0, 0, 0, 0, 1, 0, 10, 11)));
        chk({tag, "_w32"}, 128'(seen_win[2][3]), 128'(pk(12, 13, 0, 22, 23, 0, 0, 0, 0)));
`endif
        chk({tag, "_w11"}, 128'(seen_win[1][1]), 128'(pk(0, 1, 2, 10, 11, 12, 20, 21, 22)));
        chk({tag, "_last32"}, 128'(seen_last[2][3]), 128'(1));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_win", 128'(bus.out_win), 128'(0));
        chk("rst_out_x", 128'(bus.out_x), 128'(0));
        chk("rst_out_y", 128'(bus.out_y), 128'(0));
        chk("rst_out_last", 128'(bus.out_last), 128'(0));
        reset = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Continuous stream
        mon_en = 1'b1;
        win_count = 0;
        send_frame(0, 1'b0);
        drain();
        chk("s1_count", 128'(win_count), 128'(W * H));
        check_frame0("s1");

        // Random backpressure and input gaps
        rnd_ready = 1'b1;
        win_count = 0;
        send_frame(0, 1'b1);
        drain();
        chk("s2_count", 128'(win_count), 128'(W * H));
        check_frame0("s2");
        rnd_ready = 1'b0;

        // Two back-to-back frames
        win_count = 0;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        drain();
        chk("s3_count", 128'(win_count), 128'(2 * W * H));
`ifdef WIN_BORDER_REPLICATE_EN
        chk("s3_w00", 128'(seen_win[0][0]), 128'(pk(100, 100, 101, 100, 100, 101, 110, 110, 111)));
`else
        chk("s3_w00", 128'(seen_win[0][0]), 128'(pk(0, 0, 0, 0, 100, 101, 0, 110, 111)));
`endif

        // Reset after 6 pixels, then a full frame
        mon_en = 1'b0;
        send_pixels(0, 6, 1'b0);
        reset = 1'b1;
        #2;
        chk("s4_rst_valid_a", 128'(bus.out_valid), 128'(0));
        repeat (2) @(negedge clk);
        chk("s4_rst_valid_b", 128'(bus.out_valid), 128'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        win_count = 0;
        send_frame(0, 1'b0);
        drain();
        chk("s4_count", 128'(win_count), 128'(W * H));
        check_frame0("s4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
